// File: rtl/sram_arb_pkg.sv
// Shared widths and payload types for the two-requester SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORDS  = 256;
    localparam int unsigned NREQ   = 2;

    // Registered macro pin bundle (controls active-low).
    typedef struct packed {
        logic              csb;
        logic              web;
        logic              oeb;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] i;
    } sram_cmd_t;

    // Read tag travelling alongside the macro access.
    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

    localparam sram_cmd_t CMD_RESET = '{csb: 1'b1, web: 1'b1, oeb: 1'b1, a: '0, i: '0};

endpackage

// File: rtl/sram_resp_fifo.sv
// Per-requester read-response FIFO; head is presented on rdata while not empty.
module sram_resp_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         pop,
    output logic [DATA_W-1:0]            rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram1rw256x32_arbiter.sv
// Round-robin arbiter and pin sequencer for a single-port 256x32 SRAM macro
// shared by two requesters, with per-requester read-response FIFOs.
module sram1rw256x32_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0]              req_write,
    input  logic [NREQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]  req_wdata,
    output logic [NREQ-1:0]              resp_valid,
    input  logic [NREQ-1:0]              resp_ready,
    output logic [NREQ-1:0][DATA_W-1:0]  resp_rdata,
    output logic                         sram_csb,
    output logic                         sram_web,
    output logic                         sram_oeb,
    output logic [ADDR_W-1:0]            sram_a,
    output logic [DATA_W-1:0]            sram_i,
    input  logic [DATA_W-1:0]            sram_o
);

    localparam int unsigned OUT_W = $clog2(RESP_DEPTH + 1);

    logic                        prio;
    logic [NREQ-1:0][OUT_W-1:0]  outstanding;
    logic [NREQ-1:0]             eligible;
    logic [NREQ-1:0]             grant;
    logic                        gnt_any;
    logic                        gnt_id;
    logic [NREQ-1:0]             rd_accept;
    logic [NREQ-1:0]             pop;
    logic [NREQ-1:0]             push;
    logic [NREQ-1:0]             fifo_empty;
    sram_cmd_t                   cmd_d;
    sram_cmd_t                   cmd_q;
    rd_tag_t                     tag_d;
    rd_tag_t                     tag_s1;
    rd_tag_t                     tag_s2;

    // FIFO status flags are redundant with the outstanding counters.
    logic [NREQ-1:0]             fifo_full_unused;
    logic [NREQ-1:0][OUT_W-1:0]  fifo_count_unused;

    // Reads are eligible only while a response slot is guaranteed.
    always_comb begin
        eligible = '0;
        for (int k = 0; k < NREQ; k++) begin
            eligible[k] = req_valid[k]
                        & (req_write[k] | (outstanding[k] < OUT_W'(RESP_DEPTH)));
        end
    end

    // Single grant per cycle; prio breaks ties.
    always_comb begin
        grant = '0;
        if (!reset) begin
            if (&eligible) grant[prio] = 1'b1;
            else           grant       = eligible;
        end
    end

    assign gnt_any   = |grant;
    assign gnt_id    = grant[1];
    assign req_ready = grant;
    assign rd_accept = grant & ~req_write;
    assign pop       = resp_valid & resp_ready;
    assign resp_valid = ~fifo_empty;

    // Next macro command and read tag for the granted request.
    always_comb begin
        cmd_d     = cmd_q;
        cmd_d.csb = 1'b1;
        cmd_d.web = 1'b1;
        cmd_d.oeb = 1'b1;
        tag_d     = '0;
        if (gnt_any) begin
            cmd_d.csb   = 1'b0;
            cmd_d.web   = ~req_write[gnt_id];
            cmd_d.oeb   = req_write[gnt_id];
            cmd_d.a     = req_addr[gnt_id];
            cmd_d.i     = req_wdata[gnt_id];
            tag_d.valid = ~req_write[gnt_id];
            tag_d.id    = gnt_id;
        end
    end

    // Command register, tag pipeline and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_q  <= CMD_RESET;
            tag_s1 <= '0;
            tag_s2 <= '0;
            prio   <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            tag_s1 <= tag_d;
            tag_s2 <= tag_s1;
            if (gnt_any) prio <= ~gnt_id;
        end
    end

    // Reads in flight plus queued responses, per requester.
    always_ff @(posedge clock) begin
        for (int k = 0; k < NREQ; k++) begin
            if (reset) begin
                outstanding[k] <= '0;
            end else begin
                case ({rd_accept[k], pop[k]})
                    2'b10:   outstanding[k] <= outstanding[k] + OUT_W'(1);
                    2'b01:   outstanding[k] <= outstanding[k] - OUT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // Macro read data lands in the FIFO named by the stage-2 tag.
    always_comb begin
        push = '0;
        for (int k = 0; k < NREQ; k++) begin
            push[k] = tag_s2.valid & (tag_s2.id == 1'(k));
        end
    end

    for (genvar k = 0; k < NREQ; k++) begin : g_resp
        sram_resp_fifo #(
            .DEPTH  (RESP_DEPTH),
            .DATA_W (DATA_W)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (push[k]),
            .wdata (sram_o),
            .pop   (pop[k]),
            .rdata (resp_rdata[k]),
            .full  (fifo_full_unused[k]),
            .empty (fifo_empty[k]),
            .count (fifo_count_unused[k])
        );
    end

    assign sram_csb = cmd_q.csb;
    assign sram_web = cmd_q.web;
    assign sram_oeb = cmd_q.oeb;
    assign sram_a   = cmd_q.a;
    assign sram_i   = cmd_q.i;

endmodule

// File: tb/tb_sram1rw256x32_arbiter.sv
// Self-checking bench: macro model, transaction-level reference model,
// vector table, directed corner sequences and randomized traffic.
module tb_sram1rw256x32_arbiter;

    localparam int DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        req_valid, req_ready, req_write;
    logic [1:0][7:0]   req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        resp_valid, resp_ready;
    logic [1:0][31:0]  resp_rdata;
    logic              sram_csb, sram_web, sram_oeb;
    logic [7:0]        sram_a;
    logic [31:0]       sram_i, sram_o;

    sram1rw256x32_arbiter #(.RESP_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_oeb   (sram_oeb),
        .sram_a     (sram_a),
        .sram_i     (sram_i),
        .sram_o     (sram_o)
    );

    always #5 clock = ~clock;

    // Single-port macro: one access per edge, read data held until next read.
    logic [31:0] macro_mem [256];
    logic        mem_clear;
    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) macro_mem[i] <= '0;
            sram_o <= '0;
        end else if (!sram_csb) begin
            if (!sram_web)      macro_mem[sram_a] <= sram_i;
            else if (!sram_oeb) sram_o <= macro_mem[sram_a];
        end
    end

    // Reference model state: memory, expected responses with due cycle.
    typedef struct { logic [31:0] data; int due; } resp_t;
    resp_t       q0[$];
    resp_t       q1[$];
    logic [31:0] ref_mem [256];
    int          m_out [2];
    logic        m_prio;
    int          cyc;
    logic        p_known, p_csb, p_web, p_oeb;
    logic [7:0]  p_a;
    logic [31:0] p_i;
    logic [1:0]  obs_ready;
    int          pops [2];
    int          n_checks, n_err;
    int          n0, n1;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  write;
        logic [7:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [1:0]  exp_ready;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // One clock: check DUT against the model mid-cycle, then advance both.
    task automatic step();
        logic [1:0]  elig, gnt, exp_rv;
        logic [31:0] exp_rd [2];
        resp_t       e;
        int          k;
        #1;
        obs_ready = req_ready;
        exp_rv[0] = (q0.size() > 0) && (q0[0].due <= cyc);
        exp_rv[1] = (q1.size() > 0) && (q1[0].due <= cyc);
        exp_rd[0] = exp_rv[0] ? q0[0].data : '0;
        exp_rd[1] = exp_rv[1] ? q1[0].data : '0;
        for (int r = 0; r < 2; r++)
            elig[r] = req_valid[r] && (req_write[r] || m_out[r] < DEPTH);
        gnt = 2'b00;
        if (!reset) begin
            if (elig == 2'b11) gnt = m_prio ? 2'b10 : 2'b01;
            else               gnt = elig;
        end
        chk("req_ready", 32'(req_ready), 32'(gnt));
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_rv[0]) chk("resp_rdata0", resp_rdata[0], exp_rd[0]);
        if (exp_rv[1]) chk("resp_rdata1", resp_rdata[1], exp_rd[1]);
        if (p_known) begin
            chk("sram_csb", 32'(sram_csb), 32'(p_csb));
            if (!p_csb) begin
                chk("sram_web", 32'(sram_web), 32'(p_web));
                chk("sram_oeb", 32'(sram_oeb), 32'(p_oeb));
                chk("sram_a", 32'(sram_a), 32'(p_a));
                if (!p_web) chk("sram_i", sram_i, p_i);
            end
        end
        for (int r = 0; r < 2; r++)
            if (resp_valid[r] && resp_ready[r]) pops[r]++;
        if (reset) begin
            q0.delete();
            q1.delete();
            m_out[0] = 0;
            m_out[1] = 0;
            m_prio   = 1'b0;
            p_known  = 1'b1;
            p_csb    = 1'b1;
            p_web    = 1'b1;
            p_oeb    = 1'b1;
        end else begin
            if (exp_rv[0] && resp_ready[0]) begin void'(q0.pop_front()); m_out[0]--; end
            if (exp_rv[1] && resp_ready[1]) begin void'(q1.pop_front()); m_out[1]--; end
            p_csb = 1'b1;
            p_web = 1'b1;
            p_oeb = 1'b1;
            if (gnt != 2'b00) begin
                k     = gnt[1] ? 1 : 0;
                p_csb = 1'b0;
                p_web = !req_write[k];
                p_oeb = req_write[k];
                p_a   = req_addr[k];
                p_i   = req_wdata[k];
                if (req_write[k]) begin
                    ref_mem[req_addr[k]] = req_wdata[k];
                end else begin
                    e.data = ref_mem[req_addr[k]];
                    e.due  = cyc + 3;
                    if (k == 0) q0.push_back(e); else q1.push_back(e);
                    m_out[k]++;
                end
                m_prio = (k == 0);
            end
        end
        cyc++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        req_valid = 2'b00;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    task automatic clear_pops();
        pops[0] = 0;
        pops[1] = 0;
    endtask

    initial begin
        n_checks = 0; n_err = 0; cyc = 0;
        p_known = 1'b0; p_csb = 1'b1; p_web = 1'b1; p_oeb = 1'b1; p_a = '0; p_i = '0;
        m_prio = 1'b0; m_out[0] = 0; m_out[1] = 0;
        clear_pops();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        vecs[0] = '{2'b11, 2'b00, 8'h40, 8'h41, 32'h0,        32'h0,        2'b01};
        vecs[1] = '{2'b11, 2'b00, 8'h40, 8'h41, 32'h0,        32'h0,        2'b10};
        vecs[2] = '{2'b11, 2'b11, 8'h40, 8'h41, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b01};
        vecs[3] = '{2'b01, 2'b00, 8'h40, 8'h41, 32'h0,        32'h0,        2'b01};
        vecs[4] = '{2'b11, 2'b01, 8'h42, 8'h40, 32'hC2C2C2C2, 32'h0,        2'b10};
        vecs[5] = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0,        2'b00};
        vecs[6] = '{2'b10, 2'b10, 8'h00, 8'h41, 32'h0,        32'hD3D3D3D3, 2'b10};
        vecs[7] = '{2'b11, 2'b10, 8'h41, 8'h41, 32'h0,        32'hE4E4E4E4, 2'b01};

        // Reset held 3 cycles with both requesters asking.
        reset = 1'b1; mem_clear = 1'b1;
        req_valid = 2'b11; req_write = 2'b00; resp_ready = 2'b11;
        req_addr = '0; req_wdata = '0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            step();
            mem_clear = 1'b0;
            chk("rst_ready", 32'(obs_ready), 32'(2'b00));
            chk("rst_csb", 32'(sram_csb), 32'(1'b1));
            chk("rst_resp_valid", 32'(resp_valid), 32'(2'b00));
        end
        reset = 1'b0;
        step();
        chk("first_grant", 32'(obs_ready), 32'(2'b01));
        idle(4);

        // Vector table from a fresh reset (prio 0).
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            req_valid = vecs[i].valid; req_write = vecs[i].write;
            req_addr[0] = vecs[i].a0; req_addr[1] = vecs[i].a1;
            req_wdata[0] = vecs[i].d0; req_wdata[1] = vecs[i].d1;
            step();
            chk("vec_ready", 32'(obs_ready), 32'(vecs[i].exp_ready));
        end
        idle(5);

        // Write then read-back by requester 0.
        req_valid = 2'b01; req_write = 2'b01; req_addr[0] = 8'h10; req_wdata[0] = 32'hDEADBEEF;
        step();
        req_write = 2'b00;
        step();
        req_valid = 2'b00;
        step();
        chk("wr_rd_early", 32'(resp_valid[0]), 32'(1'b0));
        step();
        chk("wr_rd_valid", 32'(resp_valid[0]), 32'(1'b1));
        chk("wr_rd_data", resp_rdata[0], 32'hDEADBEEF);
        idle(2);

        // Contention: preload, then both read for 8 cycles.
        for (int i = 0; i < 8; i++) begin
            req_valid = 2'b01; req_write = 2'b01;
            req_addr[0] = 8'(8'h20 + i); req_wdata[0] = 32'h5000_0000 + 32'(i);
            step();
        end
        idle(1);
        do_reset(1);
        clear_pops(); n0 = 0; n1 = 0;
        req_valid = 2'b11; req_write = 2'b00; resp_ready = 2'b11;
        for (int i = 0; i < 8; i++) begin
            req_addr[0] = 8'(8'h20 + n0); req_addr[1] = 8'(8'h24 + n1);
            step();
            chk("contend_grant", 32'(obs_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("contend_csb", 32'(sram_csb), 32'(1'b0));
            if (obs_ready[0]) n0++;
            if (obs_ready[1]) n1++;
        end
        idle(6);
        chk("contend_resp0", 32'(pops[0]), 32'd4);
        chk("contend_resp1", 32'(pops[1]), 32'd4);

        // Backpressure on requester 1.
        do_reset(1);
        resp_ready = 2'b01; req_valid = 2'b10; req_write = 2'b00; n1 = 0;
        for (int i = 0; i < 8; i++) begin
            req_addr[1] = 8'(8'h20 + n1);
            step();
            if (obs_ready[1]) n1++;
        end
        chk("bp_accepts", 32'(n1), 32'd4);
        chk("bp_stalled", 32'(obs_ready[1]), 32'(1'b0));
        req_write = 2'b10; req_addr[1] = 8'h30; req_wdata[1] = 32'h0BADF00D;
        step();
        chk("bp_write", 32'(obs_ready), 32'(2'b10));
        req_valid = 2'b11; req_write = 2'b00; req_addr[0] = 8'h21;
        step();
        chk("bp_other", 32'(obs_ready), 32'(2'b01));
        resp_ready = 2'b11; clear_pops();
        idle(6);
        chk("bp_drain", 32'(pops[1]), 32'd4);

        // Cross-requester ordering.
        req_valid = 2'b10; req_write = 2'b10; req_addr[1] = 8'hFF; req_wdata[1] = 32'h12345678;
        step();
        req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 8'hFF;
        step();
        req_valid = 2'b00;
        step();
        step();
        chk("xorder_valid", 32'(resp_valid[0]), 32'(1'b1));
        chk("xorder_data", resp_rdata[0], 32'h12345678);
        idle(2);

        // Reset one cycle after two read accepts.
        req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 8'h10;
        step();
        step();
        req_valid = 2'b00;
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_resp", 32'(resp_valid), 32'(2'b00));
            step();
        end
        resp_ready = 2'b00; req_valid = 2'b01; n0 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs_ready[0]) n0++;
        end
        chk("midrst_fresh", 32'(n0), 32'd4);
        resp_ready = 2'b11;
        idle(6);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 199) == 0);
            req_valid    = 2'($urandom);
            req_write[0] = ($urandom_range(0, 3) == 0);
            req_write[1] = ($urandom_range(0, 3) == 0);
            req_addr[0]  = 8'($urandom_range(0, 15));
            req_addr[1]  = 8'($urandom_range(0, 15));
            req_wdata[0] = $urandom;
            req_wdata[1] = $urandom;
            resp_ready[0] = ($urandom_range(0, 9) < 7);
            resp_ready[1] = ($urandom_range(0, 9) < 7);
            step();
        end
        reset = 1'b0; resp_ready = 2'b11;
        idle(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sram1rw256x32_arbiter.md
# sram1rw256x32_arbiter

Two-requester round-robin arbiter and sequencer for one single-port 256x32 SRAM macro (active-low CSB/WEB/OEB, one access per clock, read data one cycle after the sampling edge, output held between reads). It registers all macro pins and captures macro read data into per-requester response FIFOs. Each requester gets an independent valid/ready request channel and read-response channel. It sits between two core-side clients (e.g. fetch and load/store) and the macro instance; the macro CE pin is tied to the same `clock`.

## Interface
- `RESP_DEPTH`, 4: entries per response FIFO, ≥1; 4 sustains one read per cycle for a single requester.
- `clock` in 1: single clock; also drives macro CE.
- `reset` in 1: synchronous, active-high.
- `req_valid[1:0]` in 2: request present, per requester.
- `req_ready[1:0]` out 2: request accepted this cycle (combinational from grant).
- `req_write[1:0]` in 2: 1 = write, 0 = read.
- `req_addr[0..1]` in 8 each: word address.
- `req_wdata[0..1]` in 32 each: write data.
- `resp_valid[1:0]` out 2: read data available.
- `resp_ready[1:0]` in 2: consumer takes read data.
- `resp_rdata[0..1]` out 32 each: read data, FIFO head.
- `sram_csb`, `sram_web`, `sram_oeb` out 1 each: macro controls, registered, active-low.
- `sram_a` out 8, `sram_i` out 32: macro address/data, registered.
- `sram_o` in 32: macro read data.

## Operation
- Eligibility of requester k: `req_valid[k]` and (`req_write[k]` or `outstanding[k] < RESP_DEPTH`).
- `outstanding[k]`: reads in flight plus FIFO occupancy. Increment on read accept. Decrement on pop (`resp_valid & resp_ready`). Both in the same cycle leaves it unchanged. A pop does not free a slot for a same-cycle accept.
- Arbitration: at most one grant per cycle. If both are eligible, grant `prio`. If one is eligible, grant it. After any grant, `prio` becomes the other requester.
- Grant k: `req_ready[k]=1`. The command register loads csb=0, web=~write, oeb=write, a=addr, i=wdata (i is don't-care for reads but still loads).
- No grant: command register loads csb=1, web=1, oeb=1; a and i hold.
- Read pipeline carries a 2-deep tag shift register: {valid, requester id}. When the tag reaches stage 2, `sram_o` is pushed into that requester's FIFO.
- Writes produce no response. Ordering is program order across both requesters: an access granted at T sees every write granted before T.
- Reset mid-operation: FIFOs flush, tags clear, `prio`=0, outstanding=0, and in-flight reads are discarded. A write already on macro pins at the reset edge may complete.

## Timing
- Reset values: `sram_csb`=`sram_web`=`sram_oeb`=1, `sram_a`=0, `sram_i`=0, `resp_valid`=0, `req_ready`=0 while reset is high, `prio`=0.
- Accept in cycle T. Pins are valid in T+1 and sampled by the macro at the end of T+1. `sram_o` is valid in T+2 and captured at the end of T+2. `resp_valid` rises in T+3. Read latency is 3.
- Write accepted in T is committed at the end of T+1.
- Peak macro throughput: 1 access/cycle. A single requester reads back-to-back only if RESP_DEPTH ≥ 4 and its consumer keeps `resp_ready`=1.
- FIFO full with `resp_ready`=0: that requester's reads stall. Its writes and the other requester proceed.
- `req_*` fields are sampled only in the accept cycle. `resp_rdata` is stable while `resp_valid & !resp_ready`.

## Structure
- Package `sram_arb_pkg`:
  - ADDR_W=8, DATA_W=32, WORDS=256, NREQ=2.
  - typedef `sram_cmd_t` {csb, web, oeb, a, i}.
  - typedef `rd_tag_t` {valid, id}.
- Sub-module `sram_resp_fifo`: DEPTH, DATA_W, push/pop/full/empty/count, synchronous reset. Instantiated twice.
- Arbiter, outstanding counters, command register and tag pipeline live in the top.

## Test plan
- Reset: hold reset 3 cycles with `req_valid`=2'b11 -> `req_ready`=0, `sram_csb`=1, `resp_valid`=0 throughout; first grant after release goes to requester 0.
- Write/read: req0 writes addr 0x10 = 0xDEADBEEF at T, reads 0x10 at T+1 -> `resp_valid[0]` at T+4 with `resp_rdata[0]`=0xDEADBEEF.
- Contention: both requesters read continuously for 8 cycles with resp_ready=1 -> grants alternate 0,1,0,1…; each gets 4 responses in order; `sram_csb`=0 for 8 consecutive cycles.
- Backpressure: req1 `resp_ready`=0 while issuing reads -> exactly 4 reads accepted, then `req_ready[1]`=0; req1 writes and req0 reads still granted. Raising `resp_ready` drains 4 in order.
- Cross ordering: req1 writes 0xFF = 0x12345678 at T, req0 reads 0xFF at T+1 -> response 0x12345678.
- Reset mid-flight: assert reset 1 cycle after two read accepts -> no `resp_valid` afterward, and after release `outstanding` permits 4 fresh reads.
